// File: rtl/pacman_life_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pacman_life_ctrl
//  Purpose  : Game-state sequencer for Pacman. Takes the ghost-collision
//             level and the dots-remaining flag, and from them manages lives,
//             the death freeze, respawn requests and the game-over and win
//             conditions. All game timing is counted in frames (frame_tick).
//
//  Ports    : Clk            system clock
//             Reset_n        asynchronous active-low reset
//             frame_tick     one-Clk pulse per video frame
//             over           collision level from the ghost detector
//             all_dots_eaten high when no dots remain
//             start_key      start/restart button level (synchronous)
//             lives          remaining lives
//             freeze         high = motion blocks hold position
//             respawn        one-Clk pulse, motion blocks reload positions
//             game_over      high in GAMEOVER
//             win            high in WIN
//             state          encoded FSM state (IDLE=0 RESPAWN=1 PLAY=2
//                            DYING=3 GAMEOVER=4 WIN=5)
//
//  Options  : define GRACE_INVULN_EN to make collisions harmless for the
//             first GRACE_FRAMES frames of PLAY after every respawn.
//
//  Revision : 1.0  initial release
// ============================================================================
module pacman_life_ctrl #(
   parameter int START_LIVES   = 3,
   parameter int LIFE_W        = 2,
   parameter int FREEZE_FRAMES = 60,
   parameter int GRACE_FRAMES  = 90
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              frame_tick,
   input  logic              over,
   input  logic              all_dots_eaten,
   input  logic              start_key,
   output logic [LIFE_W-1:0] lives,
   output logic              freeze,
   output logic              respawn,
   output logic              game_over,
   output logic              win,
   output logic [2:0]        state
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RESPAWN  = 3'd1;
   localparam logic [2:0] ST_PLAY     = 3'd2;
   localparam logic [2:0] ST_DYING    = 3'd3;
   localparam logic [2:0] ST_GAMEOVER = 3'd4;
   localparam logic [2:0] ST_WIN      = 3'd5;

   localparam int              CNT_W      = $clog2(FREEZE_FRAMES + 1);
   // Counter value seen just before the tick that completes the freeze.
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FREEZE_FRAMES - 1);
   localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(START_LIVES);

   logic [2:0]        state_q;
   logic [LIFE_W-1:0] lives_q;
   logic [CNT_W-1:0]  frame_cnt_q;
   logic              start_q;
   logic              armed_q;
   logic              start_edge;
   logic              grace_run;

   assign start_edge = start_key & ~start_q;

`ifdef GRACE_INVULN_EN
   localparam int              GR_W    = (GRACE_FRAMES < 1) ? 1 : $clog2(GRACE_FRAMES + 1);
   localparam logic [GR_W-1:0] GR_DONE = GR_W'(GRACE_FRAMES);

   logic [GR_W-1:0] grace_q;

   assign grace_run = (grace_q != GR_DONE);

   // Counts PLAY frames since the last respawn, saturating once the
   // invulnerability window has elapsed.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         grace_q <= '0;
      end else if (state_q == ST_RESPAWN) begin
         grace_q <= '0;
      end else if ((state_q == ST_PLAY) && frame_tick && grace_run) begin
         grace_q <= grace_q + 1'b1;
      end
   end
`else
   logic unused_grace;

   assign grace_run = 1'b0;
   // GRACE_FRAMES has no function without the grace window.
   assign unused_grace = (GRACE_FRAMES != 0);
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         lives_q     <= LIVES_INIT;
         frame_cnt_q <= '0;
         start_q     <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         start_q <= start_key;
         case (state_q)
            ST_IDLE, ST_GAMEOVER, ST_WIN: begin
               if (start_edge) begin
                  state_q <= ST_RESPAWN;
                  lives_q <= LIVES_INIT;
               end
            end
            ST_RESPAWN: begin
               armed_q     <= 1'b0;
               frame_cnt_q <= '0;
               state_q     <= ST_PLAY;
            end
            ST_PLAY: begin
               // armed is sampled before this tick's update, so a collision
               // on the very first tick after respawn is still ignored.
               if (frame_tick) begin
                  armed_q <= 1'b1;
               end
               if (all_dots_eaten) begin
                  state_q <= ST_WIN;
               end else if (armed_q && over && !grace_run) begin
                  state_q     <= ST_DYING;
                  frame_cnt_q <= '0;
                  if (lives_q != '0) begin
                     lives_q <= lives_q - 1'b1;
                  end
               end
            end
            ST_DYING: begin
               // The state leaves DYING on the tick that reaches
               // FREEZE_FRAMES, so the counter never passes that value.
               if (frame_tick) begin
                  frame_cnt_q <= frame_cnt_q + 1'b1;
                  if (frame_cnt_q == CNT_LAST) begin
                     state_q <= (lives_q == '0) ? ST_GAMEOVER : ST_RESPAWN;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are pure decodes of registered state.
   assign state     = state_q;
   assign lives     = lives_q;
   assign freeze    = (state_q != ST_PLAY);
   assign respawn   = (state_q == ST_RESPAWN);
   assign game_over = (state_q == ST_GAMEOVER);
   assign win       = (state_q == ST_WIN);

endmodule
`default_nettype wire

// File: tb/tb_pacman_life_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pacman_life_ctrl
//  Purpose  : Self-checking bench for pacman_life_ctrl. Random stimulus is
//             applied each cycle; a game-rules model predicts the outputs,
//             which are queued and compared by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pacman_life_ctrl;

   localparam int START_LIVES   = 3;
   localparam int LIFE_W        = 2;
   localparam int FREEZE_FRAMES = 4;
   localparam int GRACE_FRAMES  = 5;
`ifdef GRACE_INVULN_EN
   localparam int GRACE_EFF = GRACE_FRAMES;
`else
   localparam int GRACE_EFF = 0;
`endif

   localparam int M_IDLE = 0, M_RESPAWN = 1, M_PLAY = 2, M_DYING = 3, M_GAMEOVER = 4, M_WIN = 5;

   logic              Clk = 1'b0;
   logic              Reset_n = 1'b0;
   logic              frame_tick = 1'b0;
   logic              over = 1'b0;
   logic              all_dots_eaten = 1'b0;
   logic              start_key = 1'b0;
   logic [LIFE_W-1:0] lives;
   logic              freeze;
   logic              respawn;
   logic              game_over;
   logic              win;
   logic [2:0]        state;

   pacman_life_ctrl #(
      .START_LIVES   (START_LIVES),
      .LIFE_W        (LIFE_W),
      .FREEZE_FRAMES (FREEZE_FRAMES),
      .GRACE_FRAMES  (GRACE_FRAMES)
   ) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .frame_tick     (frame_tick),
      .over           (over),
      .all_dots_eaten (all_dots_eaten),
      .start_key      (start_key),
      .lives          (lives),
      .freeze         (freeze),
      .respawn        (respawn),
      .game_over      (game_over),
      .win            (win),
      .state          (state)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [2:0]        st;
      logic [LIFE_W-1:0] lv;
      logic              fz;
      logic              rs;
      logic              go;
      logic              wn;
   } obs_t;

   obs_t sb_q[$];
   int   passed = 0;
   int   total  = 0;

   // ---------------- game-rules reference model ----------------
   int m_mode;
   int m_lives;
   int m_freeze_left;   // frame ticks still to go in the death freeze
   int m_play_frames;   // frame ticks seen since entering PLAY
   bit m_start_prev;

   function automatic void model_reset();
      m_mode        = M_IDLE;
      m_lives       = START_LIVES;
      m_freeze_left = 0;
      m_play_frames = 0;
      m_start_prev  = 1'b0;
   endfunction

   function automatic void model_step(bit tick, bit ov, bit dots, bit sk);
      bit press;
      bit vulnerable;
      press        = sk && !m_start_prev;
      m_start_prev = sk;
      case (m_mode)
         M_IDLE, M_GAMEOVER, M_WIN: if (press) begin
            m_mode  = M_RESPAWN;
            m_lives = START_LIVES;
         end
         M_RESPAWN: begin
            m_mode        = M_PLAY;
            m_play_frames = 0;
         end
         M_PLAY: begin
            // A hit counts once a frame has passed and the grace window is over.
            vulnerable = (m_play_frames >= 1) && (m_play_frames >= GRACE_EFF);
            if (dots) m_mode = M_WIN;
            else if (ov && vulnerable) begin
               m_mode        = M_DYING;
               m_lives       = (m_lives > 0) ? m_lives - 1 : 0;
               m_freeze_left = FREEZE_FRAMES;
            end
            if (tick) m_play_frames++;
         end
         M_DYING: if (tick) begin
            m_freeze_left--;
            if (m_freeze_left == 0) m_mode = (m_lives == 0) ? M_GAMEOVER : M_RESPAWN;
         end
         default: m_mode = M_IDLE;
      endcase
   endfunction

   function automatic obs_t model_out();
      obs_t o;
      o.st = 3'(m_mode);
      o.lv = LIFE_W'(m_lives);
      o.fz = (m_mode != M_PLAY);
      o.rs = (m_mode == M_RESPAWN);
      o.go = (m_mode == M_GAMEOVER);
      o.wn = (m_mode == M_WIN);
      return o;
   endfunction

   function automatic obs_t dut_out();
      obs_t o;
      o.st = state;
      o.lv = lives;
      o.fz = freeze;
      o.rs = respawn;
      o.go = game_over;
      o.wn = win;
      return o;
   endfunction

   task automatic check(string name, obs_t act, obs_t exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s @%0t: got state=%0d lives=%0d freeze=%0b respawn=%0b game_over=%0b win=%0b, expected state=%0d lives=%0d freeze=%0b respawn=%0b game_over=%0b win=%0b",
                  name, $time, act.st, act.lv, act.fz, act.rs, act.go, act.wn,
                  exp.st, exp.lv, exp.fz, exp.rs, exp.go, exp.wn);
      end
   endtask

   // ---------------- monitor ----------------
   obs_t mon_exp;
   initial begin
      forever begin
         @(posedge Clk);
         #1;
         if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            check("cycle", dut_out(), mon_exp);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      repeat (2) @(negedge Clk);
      check("reset", dut_out(), model_out());

      for (int phase = 0; phase < 4; phase++) begin
         for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge Clk);
            if ((phase != 1) && ($urandom_range(0, 599) == 0)) begin
               Reset_n = 1'b0;
               model_reset();
            end else begin
               Reset_n    = 1'b1;
               frame_tick = ($urandom_range(0, 3) == 0);
               case (phase)
                  0:       over = ($urandom_range(0, 7) == 0);
                  1:       over = 1'b1;
                  2:       over = ($urandom_range(0, 1) == 0);
                  default: over = ($urandom_range(0, 49) == 0);
               endcase
               all_dots_eaten = (phase == 1) ? ($urandom_range(0, 499) == 0)
                                             : ($urandom_range(0, 59) == 0);
               if ($urandom_range(0, 24) == 0) start_key = ~start_key;
               model_step(frame_tick, over, all_dots_eaten, start_key);
            end
            sb_q.push_back(model_out());
         end
      end

      repeat (3) @(negedge Clk);
      if (sb_q.size() != 0) begin
         total++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pacman_life_ctrl.md
Name: pacman_life_ctrl

Overview:
Game-state sequencer that consumes the collision flag `over` from the ghost-collision detector. It manages lives, the death freeze, respawn requests and the game-over/win conditions. It sits between the collision detector and the Pacman/ghost motion blocks, driving their freeze and position-reset inputs. All timing is counted in frames using the frame_tick strobe.

Parameters:
START_LIVES, 3, lives loaded on game start; must be <= 2**LIFE_W-1
LIFE_W, 2, width of lives counter
FREEZE_FRAMES, 60, frames spent in DYING before respawn or game over
GRACE_FRAMES, 90, invulnerability frames after respawn (used only with the optional feature)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk pulse per VGA frame, synchronous to Clk
over  in  1  collision level from the ghost-collision detector
all_dots_eaten  in  1  level, high when no dots remain
start_key  in  1  start/restart button level, synchronous to Clk
lives  out  LIFE_W  remaining lives
freeze  out  1  high = motion blocks hold position
respawn  out  1  one-Clk pulse: motion blocks reload start positions
game_over  out  1  high in GAMEOVER
win  out  1  high in WIN
state  out  3  encoded FSM state, for HUD/debug (IDLE=0, RESPAWN=1, PLAY=2, DYING=3, GAMEOVER=4, WIN=5)

Behaviour:
- One clock; reset is asynchronous and active-low. Reset_n low forces:
  - state=IDLE, lives=START_LIVES, freeze=1, respawn=0, game_over=0, win=0
  - frame counter=0, start_q=0, armed=0
- start_q registers start_key each Clk. start_edge = start_key & ~start_q.
- All outputs are registered, or decoded combinationally from registered state only. No combinational path from inputs to outputs.
- IDLE: freeze=1. On start_edge -> RESPAWN and lives<=START_LIVES.
- RESPAWN: lasts exactly one Clk. respawn=1, freeze=1. Clears armed and the frame counter, then -> PLAY.
- PLAY: freeze=0.
  - armed sets on the first frame_tick seen in PLAY. Collisions are ignored until armed=1, which lets positions settle after the respawn reload.
  - Priority in the same cycle: all_dots_eaten (-> WIN) over armed&over (-> DYING).
  - On entering DYING: lives<=lives-1, saturating at 0; counter<=0.
- DYING: freeze=1. The counter increments on each frame_tick. On the frame_tick that makes counter==FREEZE_FRAMES:
  - -> GAMEOVER if lives==0, else -> RESPAWN.
  - over and all_dots_eaten are ignored in this state.
- GAMEOVER: game_over=1, freeze=1. On start_edge -> RESPAWN with lives<=START_LIVES.
- WIN: win=1, freeze=1. On start_edge -> RESPAWN with lives<=START_LIVES.
- A held start_key does not retrigger; only a new edge counts.
- An over level that stays high across states causes at most one death per PLAY entry.
- Counter width is $clog2(FREEZE_FRAMES+1). The counter never wraps; it stops at FREEZE_FRAMES.
- Asserting Reset_n mid-DYING or mid-PLAY returns to IDLE with full lives. No respawn pulse is emitted during reset.
- Latency: over high -> freeze=1 on the next Clk edge (1 cycle). DYING -> respawn pulse occurs FREEZE_FRAMES frame_ticks later plus 1 Clk.

Optional Feature:
GRACE_INVULN_EN:
- Defined: after RESPAWN, a grace counter runs for GRACE_FRAMES frame_ticks in PLAY. While it is running, over is ignored even if armed=1. The grace counter is cleared on RESPAWN and on reset.
- Undefined: no grace logic; collisions count as soon as armed=1.
- all_dots_eaten is unaffected in both cases.

Test Plan:
- Reset_n low then high, start_key held low -> state=0, lives=3, freeze=1, respawn=0, game_over=0, win=0.
- start_key 0->1 in IDLE -> exactly one respawn pulse one Clk later, then state=2, freeze=0. Holding start_key high for 100 cycles causes no further pulses.
- In PLAY after one frame_tick, over=1 for 1 Clk -> next Clk state=3, lives=2, freeze=1. After 60 frame_ticks -> respawn pulse, state=2.
- over held high continuously from game start, FREEZE_FRAMES=4 -> lives steps 3->2->1->0, with one death per PLAY entry. After the 3rd death's 4 frame_ticks -> state=4, game_over=1. Then start_edge -> lives=3, respawn pulse.
- all_dots_eaten=1 and over=1 in the same PLAY cycle -> state=5, win=1, lives unchanged at 3.
- With GRACE_INVULN_EN and GRACE_FRAMES=5: over=1 during frame ticks 1-5 after respawn -> stays in PLAY. over=1 after the 6th frame_tick -> DYING. Without the macro, the same stimulus -> DYING after the 1st frame_tick.
